// File: rtl/medidor_pkg.sv
// -----------------------------------------------------------------------------
// medidor_pkg
// Shared definitions for the period meter and later input-capture blocks.
//   estado_t    : measurement FSM encodings (IDLE / ARMED / MIDIENDO)
//   AVG_LOG_MAX : largest supported log2 averaging depth
// -----------------------------------------------------------------------------
package medidor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_MIDIENDO = 2'd2
    } estado_t;

    localparam int AVG_LOG_MAX = 4;

endpackage : medidor_pkg

// File: rtl/sincronizador_flanco.sv
// -----------------------------------------------------------------------------
// sincronizador_flanco
// Brings an asynchronous input into the clk domain and produces one-cycle
// rising/falling edge pulses aligned with the synchronised level.
//   clk      : clock
//   rst      : synchronous active-high reset
//   i_async  : asynchronous input
//   o_sync   : synchronised level (SYNC_STAGES + 1 flops behind i_async)
//   o_sube   : one-cycle pulse in the first cycle o_sync is high
//   o_baja   : one-cycle pulse in the first cycle o_sync is low
// -----------------------------------------------------------------------------
module sincronizador_flanco #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_sube,
    output logic o_baja
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   sync_d_reg;
    logic                   sube_reg;
    logic                   baja_reg;
    logic                   sync_last;

    assign sync_last = chain_reg[SYNC_STAGES-1];

    // Reset loads ones everywhere: if the input is already high when reset
    // releases, no phantom rising edge is seen (a phantom falling edge is
    // harmless to the consumers).
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg  <= '1;
            sync_d_reg <= 1'b1;
            sube_reg   <= 1'b0;
            baja_reg   <= 1'b0;
        end else begin
            chain_reg  <= {chain_reg[SYNC_STAGES-2:0], i_async};
            sync_d_reg <= sync_last;
            sube_reg   <= sync_last & ~sync_d_reg;
            baja_reg   <= ~sync_last & sync_d_reg;
        end
    end

    assign o_sync = sync_d_reg;
    assign o_sube = sube_reg;
    assign o_baja = baja_reg;

endmodule : sincronizador_flanco

// File: rtl/medidor_periodo.sv
// -----------------------------------------------------------------------------
// medidor_periodo
// Measures the number of clk cycles between consecutive rising edges of an
// asynchronous input, averages 2**AVG_LOG samples and publishes the result.
//   clk        : clock
//   rst        : synchronous active-high reset
//   i_signal   : asynchronous measured signal
//   i_enable   : measurement enable (low forces IDLE, partial window lost)
//   o_periodo  : averaged period in clk cycles
//   o_valid    : one-cycle strobe when o_periodo/o_overflow/o_alto update
//   o_overflow : some sample of the published window saturated
//   o_alto     : averaged high time (only when MEDIDOR_ALTO_EN is defined)
// Build option: define MEDIDOR_ALTO_EN to add the high-time measurement.
// -----------------------------------------------------------------------------
module medidor_periodo
    import medidor_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_signal,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_periodo,
    output logic             o_valid,
    output logic             o_overflow
`ifdef MEDIDOR_ALTO_EN
    ,
    output logic [WIDTH-1:0] o_alto
`endif
);

    localparam int ACC_W    = WIDTH + AVG_LOG;
    // One spare bit keeps the window counter non-empty when AVG_LOG = 0.
    localparam int WIN_W    = AVG_LOG + 1;
    localparam int WIN_LAST = (1 << AVG_LOG) - 1;
    localparam logic [WIDTH-1:0] UNO     = WIDTH'(1);
    localparam logic [WIN_W-1:0] WIN_FIN = WIN_W'(WIN_LAST);
    localparam logic [WIN_W-1:0] WIN_UNO = WIN_W'(1);

    logic sync_s;
    logic sube_s;
    logic baja_s;

    sincronizador_flanco #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sinc (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_signal),
        .o_sync  (sync_s),
        .o_sube  (sube_s),
        .o_baja  (baja_s)
    );

    estado_t          state_reg,   state_next;
    logic [WIDTH-1:0] cnt_reg,     cnt_next;
    logic [ACC_W-1:0] acc_reg,     acc_next;
    logic [WIN_W-1:0] win_reg,     win_next;
    logic             win_ovf_reg, win_ovf_next;
    logic [WIDTH-1:0] periodo_reg, periodo_next;
    logic             valid_reg,   valid_next;
    logic             ovf_reg,     ovf_next;

    logic [WIDTH-1:0] muestra;
    logic             muestra_ovf;
    logic [ACC_W-1:0] acc_sum;
    logic             marca_ovf;

    // A saturated counter means the true period is unknown: report all ones.
    assign muestra_ovf = (cnt_reg == '1);
    assign muestra     = muestra_ovf ? cnt_reg : cnt_reg + UNO;
    assign acc_sum     = acc_reg + ACC_W'(muestra);

`ifdef MEDIDOR_ALTO_EN
    logic [WIDTH-1:0] alto_cnt_reg, alto_cnt_next;
    logic [ACC_W-1:0] alto_acc_reg, alto_acc_next;
    logic [WIDTH-1:0] alto_out_reg, alto_out_next;
    logic [ACC_W-1:0] alto_sum;
    logic             alto_ovf;

    assign alto_ovf  = (alto_cnt_reg == '1);
    assign alto_sum  = alto_acc_reg + ACC_W'(alto_cnt_reg);
    assign marca_ovf = muestra_ovf | alto_ovf;

    // The sube cycle is already the first high cycle, so the count restarts
    // at one; it then freezes on baja or saturation until the next sube.
    always_comb begin
        alto_cnt_next = alto_cnt_reg;
        if (state_reg == ST_IDLE || !i_enable) begin
            alto_cnt_next = '0;
        end else if (sube_s) begin
            alto_cnt_next = UNO;
        end else if (sync_s && !baja_s && !alto_ovf) begin
            alto_cnt_next = alto_cnt_reg + UNO;
        end
    end

    assign o_alto = alto_out_reg;
`else
    logic unused_sync_baja;

    assign marca_ovf        = muestra_ovf;
    assign unused_sync_baja = sync_s ^ baja_s;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        win_next     = win_reg;
        win_ovf_next = win_ovf_reg;
        periodo_next = periodo_reg;
        ovf_next     = ovf_reg;
        valid_next   = 1'b0;
`ifdef MEDIDOR_ALTO_EN
        alto_acc_next = alto_acc_reg;
        alto_out_next = alto_out_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                cnt_next     = '0;
                acc_next     = '0;
                win_next     = '0;
                win_ovf_next = 1'b0;
`ifdef MEDIDOR_ALTO_EN
                alto_acc_next = '0;
`endif
                if (i_enable) begin
                    state_next = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (!i_enable) begin
                    state_next = ST_IDLE;
                end else if (sube_s) begin
                    state_next = ST_MIDIENDO;
                    cnt_next   = '0;
                end
            end

            ST_MIDIENDO: begin
                if (!i_enable) begin
                    // Drop the partial window; the outputs keep the last result.
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    acc_next     = '0;
                    win_next     = '0;
                    win_ovf_next = 1'b0;
`ifdef MEDIDOR_ALTO_EN
                    alto_acc_next = '0;
`endif
                end else if (sube_s) begin
                    cnt_next = '0;
                    if (win_reg == WIN_FIN) begin
                        periodo_next = WIDTH'(acc_sum >> AVG_LOG);
                        ovf_next     = win_ovf_reg | marca_ovf;
                        valid_next   = 1'b1;
                        acc_next     = '0;
                        win_next     = '0;
                        win_ovf_next = 1'b0;
`ifdef MEDIDOR_ALTO_EN
                        alto_out_next = WIDTH'(alto_sum >> AVG_LOG);
                        alto_acc_next = '0;
`endif
                    end else begin
                        acc_next     = acc_sum;
                        win_next     = win_reg + WIN_UNO;
                        win_ovf_next = win_ovf_reg | marca_ovf;
`ifdef MEDIDOR_ALTO_EN
                        alto_acc_next = alto_sum;
`endif
                    end
                end else if (!muestra_ovf) begin
                    cnt_next = cnt_reg + UNO;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            win_reg     <= '0;
            win_ovf_reg <= 1'b0;
            periodo_reg <= '0;
            valid_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
`ifdef MEDIDOR_ALTO_EN
            alto_cnt_reg <= '0;
            alto_acc_reg <= '0;
            alto_out_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            win_reg     <= win_next;
            win_ovf_reg <= win_ovf_next;
            periodo_reg <= periodo_next;
            valid_reg   <= valid_next;
            ovf_reg     <= ovf_next;
`ifdef MEDIDOR_ALTO_EN
            alto_cnt_reg <= alto_cnt_next;
            alto_acc_reg <= alto_acc_next;
            alto_out_reg <= alto_out_next;
`endif
        end
    end

    assign o_periodo  = periodo_reg;
    assign o_valid    = valid_reg;
    assign o_overflow = ovf_reg;

endmodule : medidor_periodo

// File: doc/medidor_periodo.md
# medidor_periodo

Parametrised period meter for an asynchronous digital input. Synchronises `i_signal` and counts `clk` cycles between consecutive rising edges. Optionally averages over 2^AVG_LOG periods, and publishes each result with a one-cycle valid strobe and an overflow flag. Sits between external pulse inputs and the register or display logic in the sequential-problems set.

## Interface
- WIDTH, 16, width of the period counter and of `o_periodo` (≥4).
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (≥2).
- AVG_LOG, 0, log2 of the number of periods averaged per result (0..4).
- clk  input  1  single clock; every register is on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- i_signal  input  1  asynchronous measured signal.
- i_enable  input  1  measurement enable; low forces IDLE.
- o_periodo  output  WIDTH  averaged period in `clk` cycles; reset 0.
- o_valid  output  1  one-cycle pulse when `o_periodo` updates; reset 0.
- o_overflow  output  1  set if any sample in the window saturated; updates with `o_valid`; reset 0.
- o_alto  output  WIDTH  averaged high time in `clk` cycles; present only with MEDIDOR_ALTO_EN; reset 0.

## Operation
- `i_signal` passes through SYNC_STAGES flops.
- Rising-edge pulse `sube` = synced & ~synced_prev. Falling-edge pulse `baja` = ~synced & synced_prev.
- States:
  - IDLE: entered on reset or when `i_enable`=0. Counter, accumulator and window count are cleared. Outputs hold their last values.
  - ARMED: entered from IDLE when `i_enable`=1. The first `sube` moves to MIDIENDO and clears `cnt`. No sample is produced.
  - MIDIENDO: `cnt` increments every cycle without `sube`.
    - On `sube`: sample = `cnt`+1, `cnt` ← 0, and the FSM stays in MIDIENDO.
    - Edges N cycles apart give sample N.
- Saturation: `cnt` stops at 2^WIDTH−1. A sample taken from a saturated `cnt` is reported as all ones and marks overflow for the window.
- Averaging:
  - Accumulator width is WIDTH+AVG_LOG.
  - After 2^AVG_LOG samples: `o_periodo` ← acc >> AVG_LOG (truncating), `o_overflow` ← OR of the window's overflow marks, `o_valid` pulses, and acc and window count clear.
  - With AVG_LOG=0, every sample produces a result.
- `i_enable` falling while in MIDIENDO:
  - The partial window is discarded and the FSM goes to IDLE the next cycle.
  - Re-enabling needs a fresh arming edge.
- `rst` has priority over everything, including a coincident `sube`.

## Timing
- `i_signal` rising to `sube`: SYNC_STAGES+1 cycles.
- `sube` closing a window to `o_valid`=1: 1 cycle. `o_periodo`, `o_overflow` and `o_alto` are stable in that cycle and held afterwards.
- The minimum measurable period is 2 cycles. Faster input is not required to be measured correctly.
- `o_valid` is never high for two consecutive cycles unless the input period is ≤2 with AVG_LOG=0.
- After `rst` deasserts, the first `o_valid` comes no earlier than the 2^AVG_LOG+1-th rising edge.

## Configuration
- MEDIDOR_ALTO_EN defined:
  - Adds the `o_alto` port and a second WIDTH-bit counter.
  - The counter clears on `sube`, increments while synced is high, and stops on `baja` or saturation.
  - The high time is summed into its own accumulator on each `sube` and published with the same `o_valid` as `o_periodo`.
  - A saturated high time also sets `o_overflow`.
- MEDIDOR_ALTO_EN undefined: no `o_alto` port, no high-time logic. Period behaviour is identical in both builds.

## Structure
- Shared package/header `medidor_pkg`:
  - State encodings: ST_IDLE=2'd0, ST_ARMED=2'd1, ST_MIDIENDO=2'd2.
  - AVG_LOG maximum constant.
- Sub-module `sincronizador_flanco`:
  - Parameter SYNC_STAGES.
  - Ports: clk, rst, i_async, o_sync, o_sube, o_baja.
  - Reused by later input-capture blocks.
- FSM, counters and accumulators live in `medidor_periodo`.

## Test plan
- WIDTH=8, AVG_LOG=0, square wave of period 10 cycles, `i_enable`=1:
  - No `o_valid` on the first edge.
  - Then `o_periodo`=10, `o_overflow`=0, `o_valid` once every 10 cycles.
- AVG_LOG=2, periods 10,12,10,12 → exactly one `o_valid`, with `o_periodo`=11.
- WIDTH=8, one period of 300 then one of 50:
  - First result: `o_periodo`=255, `o_overflow`=1.
  - Next result: `o_periodo`=50, `o_overflow`=0.
- `i_enable` dropped for 5 cycles mid-period, then period-20 input:
  - Partial window discarded; `o_periodo` holds its old value.
  - First `o_valid` on the second rising edge after re-enable, with value 20.
- `rst` pulsed for 1 cycle mid-count, coincident with `sube` → next cycle all outputs are 0, and the following edge arms without a result.
- MEDIDOR_ALTO_EN, period 10, high 3, AVG_LOG=0 → `o_alto`=3 and `o_periodo`=10 on the same `o_valid`.
